// File: rtl/alu_issue_unit.sv
// Decodes a MIPS instruction to ALU control/operands, holds them for ISSUE_CYCLES, then returns the captured result over valid/ready.
// Optional feature macro ILLEGAL_TRAP_EN: adds o_out_illegal and forces result/taken to 0 for undecodable instructions.
module alu_issue_unit #(
    parameter int ISSUE_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_rs_data,
    input  logic [31:0] i_rt_data,
    output logic [31:0] o_alu_a,
    output logic [31:0] o_alu_b,
    output logic [3:0]  o_alu_ctrl,
    input  logic [31:0] i_alu_w,
    input  logic        i_alu_zero,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_out_result,
    output logic        o_out_taken
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic        o_out_illegal
`endif
);
    localparam int CW = (ISSUE_CYCLES > 1) ? $clog2(ISSUE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(ISSUE_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
    typedef enum logic [1:0] {BR_NONE, BR_EQ, BR_NE} br_t;

    state_t         r_state, w_next;
    br_t            r_br, w_br;
    logic [CW-1:0]  r_cnt;
    logic [31:0]    r_alu_a, r_alu_b, w_alu_a, w_alu_b;
    logic [3:0]     r_alu_ctrl, w_alu_ctrl;
    logic [31:0]    r_out_result;
    logic           r_out_taken;
    logic           w_accept, w_capture, w_taken;

    logic [5:0]     w_op, w_funct;
    logic [4:0]     w_shamt;
    logic [31:0]    w_simm, w_zimm;
    logic [9:0]     w_unused_fields;

    assign w_op            = i_instr[31:26];
    assign w_funct         = i_instr[5:0];
    assign w_shamt         = i_instr[10:6];
    assign w_simm          = {{16{i_instr[15]}}, i_instr[15:0]};
    assign w_zimm          = {16'b0, i_instr[15:0]};
    assign w_unused_fields = i_instr[25:16];

    always_comb begin
        w_alu_ctrl = 4'hF;
        w_alu_a    = '0;
        w_alu_b    = '0;
        w_br       = BR_NONE;
        case (w_op)
            6'h00: begin
                w_alu_a = i_rs_data;
                w_alu_b = i_rt_data;
                case (w_funct)
                    6'h20: w_alu_ctrl = 4'h2;
                    6'h21: w_alu_ctrl = 4'h8;
                    6'h22: w_alu_ctrl = 4'h6;
                    6'h23: w_alu_ctrl = 4'h9;
                    6'h24: w_alu_ctrl = 4'h0;
                    6'h25: w_alu_ctrl = 4'h1;
                    6'h26: w_alu_ctrl = 4'hA;
                    6'h27: w_alu_ctrl = 4'hC;
                    6'h2A: w_alu_ctrl = 4'h7;
                    6'h2B: w_alu_ctrl = 4'hB;
                    6'h00: begin w_alu_ctrl = 4'h3; w_alu_a = {27'b0, w_shamt}; end
                    6'h02: begin w_alu_ctrl = 4'h4; w_alu_a = {27'b0, w_shamt}; end
                    6'h03: begin w_alu_ctrl = 4'hD; w_alu_a = {27'b0, w_shamt}; end
                    6'h04: begin w_alu_ctrl = 4'h3; w_alu_a = {27'b0, i_rs_data[4:0]}; end
                    6'h06: begin w_alu_ctrl = 4'h4; w_alu_a = {27'b0, i_rs_data[4:0]}; end
                    6'h07: begin w_alu_ctrl = 4'hD; w_alu_a = {27'b0, i_rs_data[4:0]}; end
                    default: begin w_alu_a = '0; w_alu_b = '0; end
                endcase
            end
            6'h08: begin w_alu_ctrl = 4'h2; w_alu_a = i_rs_data; w_alu_b = w_simm; end
            6'h09: begin w_alu_ctrl = 4'h8; w_alu_a = i_rs_data; w_alu_b = w_simm; end
            6'h0A: begin w_alu_ctrl = 4'h7; w_alu_a = i_rs_data; w_alu_b = w_simm; end
            6'h0B: begin w_alu_ctrl = 4'hB; w_alu_a = i_rs_data; w_alu_b = w_simm; end
            6'h0C: begin w_alu_ctrl = 4'h0; w_alu_a = i_rs_data; w_alu_b = w_zimm; end
            6'h0D: begin w_alu_ctrl = 4'h1; w_alu_a = i_rs_data; w_alu_b = w_zimm; end
            6'h0E: begin w_alu_ctrl = 4'hA; w_alu_a = i_rs_data; w_alu_b = w_zimm; end
            6'h0F: begin w_alu_ctrl = 4'hE; w_alu_b = w_zimm; end
            6'h04: begin w_alu_ctrl = 4'h6; w_alu_a = i_rs_data; w_alu_b = i_rt_data; w_br = BR_EQ; end
            6'h05: begin w_alu_ctrl = 4'h6; w_alu_a = i_rs_data; w_alu_b = i_rt_data; w_br = BR_NE; end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_in_valid) w_next = S_EXEC;
            S_EXEC:  if (r_cnt == '0) w_next = S_DONE;
            S_DONE:  if (i_out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_accept  = (r_state == S_IDLE) && i_in_valid;
    assign w_capture = (r_state == S_EXEC) && (r_cnt == '0);
    assign w_taken   = (r_br == BR_EQ) ? i_alu_zero :
                       (r_br == BR_NE) ? ~i_alu_zero : 1'b0;

    // Code 1111 is produced only for undecodable instructions, so it doubles as the illegal marker.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_ctrl   <= '0;
            r_br         <= BR_NONE;
            r_cnt        <= '0;
            r_out_result <= '0;
            r_out_taken  <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            o_out_illegal <= 1'b0;
`endif
        end else if (w_accept) begin
            r_alu_a    <= w_alu_a;
            r_alu_b    <= w_alu_b;
            r_alu_ctrl <= w_alu_ctrl;
            r_br       <= w_br;
            r_cnt      <= CNT_INIT;
`ifdef ILLEGAL_TRAP_EN
            o_out_illegal <= 1'b0;
`endif
        end else if (w_capture) begin
`ifdef ILLEGAL_TRAP_EN
            r_out_result  <= (r_alu_ctrl == 4'hF) ? '0 : i_alu_w;
            r_out_taken   <= (r_alu_ctrl == 4'hF) ? 1'b0 : w_taken;
            o_out_illegal <= (r_alu_ctrl == 4'hF);
`else
            r_out_result <= i_alu_w;
            r_out_taken  <= w_taken;
`endif
        end else if (r_state == S_EXEC) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_in_ready   = (r_state == S_IDLE);
    assign o_out_valid  = (r_state == S_DONE);
    assign o_alu_a      = r_alu_a;
    assign o_alu_b      = r_alu_b;
    assign o_alu_ctrl   = r_alu_ctrl;
    assign o_out_result = r_out_result;
    assign o_out_taken  = r_out_taken;
endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural ALU closing the loop on the ALU ports.
module tb_alu_issue_unit;
    localparam int IC = 1;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_in_valid = 1'b0;
    logic        o_in_ready;
    logic [31:0] i_instr = '0, i_rs_data = '0, i_rt_data = '0;
    logic [31:0] o_alu_a, o_alu_b;
    logic [3:0]  o_alu_ctrl;
    logic [31:0] i_alu_w;
    logic        i_alu_zero;
    logic        o_out_valid;
    logic        i_out_ready = 1'b0;
    logic [31:0] o_out_result;
    logic        o_out_taken;
`ifdef ILLEGAL_TRAP_EN
    logic        o_out_illegal;
`endif

    int n_checks = 0;
    int n_errors = 0;

    alu_issue_unit #(.ISSUE_CYCLES(IC)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_instr(i_instr), .i_rs_data(i_rs_data), .i_rt_data(i_rt_data),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_ctrl(o_alu_ctrl),
        .i_alu_w(i_alu_w), .i_alu_zero(i_alu_zero),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_out_result(o_out_result), .o_out_taken(o_out_taken)
`ifdef ILLEGAL_TRAP_EN
        , .o_out_illegal(o_out_illegal)
`endif
    );

    always #5 i_clk = ~i_clk;

    always_comb begin
        i_alu_w = '0;
        case (o_alu_ctrl)
            4'h0: i_alu_w = o_alu_a & o_alu_b;
            4'h1: i_alu_w = o_alu_a | o_alu_b;
            4'h2: i_alu_w = o_alu_a + o_alu_b;
            4'h3: i_alu_w = o_alu_b << o_alu_a[4:0];
            4'h4: i_alu_w = o_alu_b >> o_alu_a[4:0];
            4'h6: i_alu_w = o_alu_a - o_alu_b;
            4'h7: i_alu_w = {31'b0, $signed(o_alu_a) < $signed(o_alu_b)};
            4'h8: i_alu_w = o_alu_a + o_alu_b;
            4'h9: i_alu_w = o_alu_a - o_alu_b;
            4'hA: i_alu_w = o_alu_a ^ o_alu_b;
            4'hB: i_alu_w = {31'b0, o_alu_a < o_alu_b};
            4'hC: i_alu_w = ~(o_alu_a | o_alu_b);
            4'hD: i_alu_w = $unsigned($signed(o_alu_b) >>> o_alu_a[4:0]);
            4'hE: i_alu_w = o_alu_b << 16;
            default: i_alu_w = '0;
        endcase
    end
    assign i_alu_zero = (i_alu_w == 32'b0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [4:0] sh, input logic [5:0] fn);
        return {6'h00, 5'd1, 5'd2, 5'd3, sh, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd1, 5'd2, imm};
    endfunction

    task automatic issue(input string tag, input logic [31:0] ins, rs, rt, ea, eb, input logic [3:0] ec);
        int n;
        i_instr = ins; i_rs_data = rs; i_rt_data = rt; i_in_valid = 1'b1;
        @(posedge i_clk); #1;
        i_in_valid = 1'b0;
        i_instr = 32'hFFFF_FFFF; i_rs_data = 32'hDEAD_BEEF; i_rt_data = 32'hDEAD_BEEF;
        chk({tag, "_alu_a"}, o_alu_a, ea);
        chk({tag, "_alu_b"}, o_alu_b, eb);
        chk({tag, "_ctrl"}, 32'(o_alu_ctrl), 32'(ec));
        chk({tag, "_exec_rdy"}, 32'(o_in_ready), 32'd0);
        n = 0;
        while (!o_out_valid && n < 20) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(IC));
    endtask

    task automatic retire(input string tag);
        i_out_ready = 1'b1;
        @(posedge i_clk); #1;
        i_out_ready = 1'b0;
        chk({tag, "_ret_rdy"}, 32'(o_in_ready), 32'd1);
        chk({tag, "_ret_vld"}, 32'(o_out_valid), 32'd0);
    endtask

    task automatic vec(input string tag, input logic [31:0] ins, rs, rt, ea, eb,
                       input logic [3:0] ec, input logic [31:0] er, input logic et, input logic eill);
        issue(tag, ins, rs, rt, ea, eb, ec);
        chk({tag, "_result"}, o_out_result, er);
        chk({tag, "_taken"}, 32'(o_out_taken), 32'(et));
`ifdef ILLEGAL_TRAP_EN
        chk({tag, "_illegal"}, 32'(o_out_illegal), 32'(eill));
`else
        if (eill) chk({tag, "_ill_ctrl"}, 32'(o_alu_ctrl), 32'hF);
`endif
        retire(tag);
    endtask

    initial begin
        repeat (3) @(posedge i_clk);
        #1 i_reset = 1'b0;
        chk("rst_in_ready", 32'(o_in_ready), 32'd1);
        chk("rst_out_valid", 32'(o_out_valid), 32'd0);
        chk("rst_alu_a", o_alu_a, 32'd0);
        chk("rst_alu_b", o_alu_b, 32'd0);
        chk("rst_ctrl", 32'(o_alu_ctrl), 32'd0);
        chk("rst_result", o_out_result, 32'd0);
        chk("rst_taken", 32'(o_out_taken), 32'd0);
`ifdef ILLEGAL_TRAP_EN
        chk("rst_illegal", 32'(o_out_illegal), 32'd0);
`endif

        vec("add",  r_ins(5'd0, 6'h20), 32'd5, 32'd7, 32'd5, 32'd7, 4'h2, 32'd12, 1'b0, 1'b0);
        vec("sra",  r_ins(5'd4, 6'h03), 32'h1234, 32'h8000_0000, 32'd4, 32'h8000_0000, 4'hD, 32'hF800_0000, 1'b0, 1'b0);
        vec("addi", i_ins(6'h08, 16'hFFFF), 32'd1, 32'h77, 32'd1, 32'hFFFF_FFFF, 4'h2, 32'd0, 1'b0, 1'b0);
        vec("ori",  i_ins(6'h0D, 16'hFFFF), 32'h1234_0000, 32'h77, 32'h1234_0000, 32'h0000_FFFF, 4'h1, 32'h1234_FFFF, 1'b0, 1'b0);
        vec("beq",  i_ins(6'h04, 16'h0010), 32'd9, 32'd9, 32'd9, 32'd9, 4'h6, 32'd0, 1'b1, 1'b0);
        vec("bne",  i_ins(6'h05, 16'h0010), 32'd9, 32'd9, 32'd9, 32'd9, 4'h6, 32'd0, 1'b0, 1'b0);
        vec("bne2", i_ins(6'h05, 16'h0010), 32'd9, 32'd4, 32'd9, 32'd4, 4'h6, 32'd5, 1'b1, 1'b0);
        vec("sllv", r_ins(5'd0, 6'h04), 32'h23, 32'd1, 32'd3, 32'd1, 4'h3, 32'd8, 1'b0, 1'b0);
        vec("lui",  i_ins(6'h0F, 16'hABCD), 32'h55, 32'h77, 32'd0, 32'h0000_ABCD, 4'hE, 32'hABCD_0000, 1'b0, 1'b0);
        vec("slt",  r_ins(5'd0, 6'h2A), 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd1, 4'h7, 32'd1, 1'b0, 1'b0);
        vec("sltu", r_ins(5'd0, 6'h2B), 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd1, 4'hB, 32'd0, 1'b0, 1'b0);
        vec("xor",  r_ins(5'd0, 6'h26), 32'hF0F0, 32'hFF00, 32'hF0F0, 32'hFF00, 4'hA, 32'h0FF0, 1'b0, 1'b0);
        vec("ill",  {6'h3F, 26'h0ABCDEF}, 32'd5, 32'd7, 32'd0, 32'd0, 4'hF, 32'd0, 1'b0, 1'b1);
        vec("ill_fn", r_ins(5'd0, 6'h3F), 32'd5, 32'd7, 32'd0, 32'd0, 4'hF, 32'd0, 1'b0, 1'b1);
        vec("andi", i_ins(6'h0C, 16'h00F0), 32'hFF, 32'h77, 32'hFF, 32'h0000_00F0, 4'h0, 32'hF0, 1'b0, 1'b0);

        // Downstream stall with a competing upstream request.
        issue("stall", r_ins(5'd0, 6'h22), 32'd20, 32'd7, 32'd20, 32'd7, 4'h6);
        i_instr = r_ins(5'd0, 6'h20); i_rs_data = 32'd1; i_rt_data = 32'd1; i_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge i_clk); #1;
            chk("stall_vld", 32'(o_out_valid), 32'd1);
            chk("stall_res", o_out_result, 32'd13);
            chk("stall_rdy", 32'(o_in_ready), 32'd0);
            chk("stall_ctrl", 32'(o_alu_ctrl), 32'h6);
        end
        i_in_valid = 1'b0;
        retire("stall");

        i_out_ready = 1'b1;
        repeat (2) @(posedge i_clk);
        #1 i_out_ready = 1'b0;
        chk("idle_ordy_vld", 32'(o_out_valid), 32'd0);
        chk("idle_ordy_rdy", 32'(o_in_ready), 32'd1);

        // Reset while the transaction is in EXEC.
        i_instr = r_ins(5'd0, 6'h20); i_rs_data = 32'd5; i_rt_data = 32'd7; i_in_valid = 1'b1;
        @(posedge i_clk); #1;
        i_in_valid = 1'b0;
        chk("rexec_rdy0", 32'(o_in_ready), 32'd0);
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        chk("rexec_vld", 32'(o_out_valid), 32'd0);
        chk("rexec_rdy", 32'(o_in_ready), 32'd1);
        chk("rexec_res", o_out_result, 32'd0);
        chk("rexec_ctrl", 32'(o_alu_ctrl), 32'd0);
        chk("rexec_a", o_alu_a, 32'd0);
        @(posedge i_clk); #1;
        chk("rexec_vld2", 32'(o_out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Initiator-side sequencer for the 32-bit MIPS ALU. Accepts one instruction word plus its register operands over a valid/ready handshake and decodes it to the 4-bit ALU control code. It then drives the ALU operand/control ports, captures the ALU result and Zero flag after a settle interval, and presents the result (with branch resolution) downstream over a second valid/ready handshake. It sits between the register-read stage and writeback in the multi-cycle datapath.

## Interface
- ISSUE_CYCLES, 1: cycles ALU inputs are held stable before result capture (>=1).
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- InValid  in  1  upstream has a transaction.
- InReady  out  1  unit can accept (high only in IDLE).
- Instr  in  32  MIPS instruction word.
- RsData  in  32  rs register value.
- RtData  in  32  rt register value.
- AluA  out  32  ALU BusA (shift amount for shifts).
- AluB  out  32  ALU BusB.
- AluCtrl  out  4  ALU control code.
- AluW  in  32  ALU BusW.
- AluZero  in  1  ALU Zero.
- OutValid  out  1  result available.
- OutReady  in  1  downstream accepts.
- OutResult  out  32  captured AluW.
- OutTaken  out  1  branch taken (BEQ/BNE only, else 0).
- OutIllegal  out  1  undecodable instruction (only with ILLEGAL_TRAP_EN).

## Operation
- Codes: AND 0000, OR 0001, ADD 0010, SLL 0011, SRL 0100, SUB 0110, SLT 0111, ADDU 1000, SUBU 1001, XOR 1010, SLTU 1011, NOR 1100, SRA 1101, LUI 1110, illegal 1111.
- R-type (op 0), funct -> code, A/B: 0x20 ADD, 0x21 ADDU, 0x22 SUB, 0x23 SUBU, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x2B SLTU, with A=rs, B=rt; 0x00 SLL, 0x02 SRL, 0x03 SRA, with A={27'b0,shamt}, B=rt; 0x04 SLL, 0x06 SRL, 0x07 SRA, with A={27'b0,rs[4:0]}, B=rt.
- I-type, A=rs, B=imm: 0x08 ADD, 0x09 ADDU, 0x0A SLT, 0x0B SLTU use sign-extended imm. 0x0C AND, 0x0D OR, 0x0E XOR use zero-extended imm.
- 0x0F LUI: A=0, B={16'b0,imm}.
- 0x04 BEQ / 0x05 BNE: SUB, A=rs, B=rt. OutTaken=AluZero (BEQ) or ~AluZero (BNE).
- Any other op/funct is illegal: code 1111, A=B=0.
- FSM IDLE -> EXEC -> DONE -> IDLE.
  - IDLE: InReady=1; on InValid, register decoded A/B/ctrl/branch-type, counter=ISSUE_CYCLES-1, go EXEC.
  - EXEC: ALU ports driven from registers; at counter=0 capture AluW, AluZero into output registers, go DONE; else decrement.
  - DONE: OutValid=1, outputs stable; on OutReady go IDLE.
- ALU port registers hold last values in IDLE/DONE (no glitching to ALU).

## Timing
- Reset: state IDLE, AluA=AluB=0, AluCtrl=0000, OutValid=0, OutResult=0, OutTaken=0, OutIllegal=0, counter=0; InReady=1 from first cycle after reset.
- Accept at edge k -> ALU ports valid in cycle k+1 -> capture at edge k+ISSUE_CYCLES -> OutValid high from cycle k+ISSUE_CYCLES+1.
- Throughput: one transaction per ISSUE_CYCLES+2 cycles with OutReady held high.
- OutReady stalled: DONE held indefinitely; InReady stays 0; no transaction dropped.
- InValid while InReady=0: ignored; upstream must hold.
- OutReady high while OutValid=0: no effect.
- Reset mid-operation: wins over all events; in-flight transaction discarded, outputs return to reset values next cycle.

## Configuration
- ILLEGAL_TRAP_EN defined: OutIllegal port present; illegal instruction completes with OutResult=0, OutTaken=0, OutIllegal=1 (cleared at next accept).
- Undefined: no OutIllegal port; illegal instruction completes silently with OutResult equal to the ALU output for code 1111 (0).

## Test plan
- Reset then idle: all outputs at reset values, InReady=1, OutValid=0.
- ADD R-type, rs=5, rt=7, ISSUE_CYCLES=1: AluCtrl=0010, AluA=5, AluB=7; OutValid at cycle k+2, OutResult=12.
- SRA funct 0x03, shamt=4, rt=0x80000000: AluA=4, AluCtrl=1101, OutResult=0xF8000000.
- ADDI imm=0xFFFF, rs=1 -> AluB=0xFFFFFFFF, OutResult=0. ORI imm=0xFFFF -> AluB=0x0000FFFF.
- BEQ rs=rt=9 -> OutTaken=1, OutResult=0. BNE same operands -> OutTaken=0.
- OutReady low 5 cycles in DONE: OutValid/OutResult stable, InReady=0. Reset asserted in EXEC: next cycle IDLE, OutValid=0. With ILLEGAL_TRAP_EN, op 0x3F: OutIllegal=1, OutResult=0.
